ifetch_pc_ctrl: RTL and testbench
=================================

Name: ifetch_pc_ctrl

Overview:
- Instruction-fetch stage directly upstream of the execute unit.
- Owns the PC register and fetches one instruction per step from instruction memory through a req/ready handshake.
- Presents the instruction and PC+4 to decode/execute, and consumes execute's branch target (Addr_result) and Zero flag to form the next PC.
- Also produces the jal link address.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 14, instruction-memory word-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Addr_result  in  32  branch target from execute (PC+4 + offset<<2).
- Zero  in  1  execute zero flag.
- Read_data_1  in  32  rs value, jr target.
- Branch  in  1  beq.
- nBranch  in  1  bne.
- Jmp  in  1  j.
- Jal  in  1  jal.
- Jr  in  1  jr.
- stall  in  1  hold current instruction; PC does not advance.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  word address = PC[ADDR_W+1:2].
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched word.
- Instruction  out  32  registered current instruction.
- instr_valid  out  1  Instruction valid; execute/writeback may commit.
- branch_base_addr  out  32  PC+4 of current instruction (combinational from PC register).
- link_addr  out  32  PC+4 captured at jal retire.
- pc_out  out  32  current PC.

Behaviour:
- Reset (reset==0 at a rising edge):
  - PC=RESET_PC, Instruction=0, instr_valid=0, link_addr=0, state=FETCH.
  - imem_req is 0 while reset is asserted.
  - Reset overrides everything. Any outstanding fetch is abandoned and a late imem_ready is ignored.
- FSM states: FETCH, EXEC (plus HALT, only with the optional feature).
- FETCH:
  - imem_req=1, imem_addr driven from PC, instr_valid=0.
  - On imem_ready=1: Instruction<=imem_rdata, go EXEC. Latency is one cycle minimum; ready may arrive any number of cycles later.
- EXEC:
  - instr_valid=1, imem_req=0. Execute evaluates combinationally within the cycle.
  - If stall=1: remain in EXEC; PC, Instruction and link_addr hold.
  - Else: PC<=next_pc, go FETCH. If Jal=1, link_addr<=PC+4.
- next_pc priority:
  1. Jr: Read_data_1 with bits[1:0] forced to 0.
  2. Jmp|Jal: {PC+4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch&Zero) | (nBranch&~Zero): Addr_result.
  4. Otherwise: PC+4.
- Arithmetic:
  - PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - imem_addr truncates the PC to ADDR_W bits.
- Boundary cases:
  - imem_ready outside FETCH is ignored.
  - Branch and nBranch both 1 is illegal: result is the OR of both taken terms; not checked.
  - Multiple jump controls asserted: priority above applies.

Optional Feature:
- Macro IFETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, sticky, reset 0) and state HALT.
  - In EXEC with stall=0 and next_pc[1:0]!=0 (Jr source): PC holds, addr_err<=1, go HALT.
  - HALT: imem_req=0, instr_valid=0. Exit only by reset.
- Undefined: no addr_err port, no HALT state; Jr target low bits are silently masked.

Decomposition:
- Package ifetch_pkg:
  - state enum {FETCH, EXEC, HALT}
  - RESET_PC default
  - constant PC_INC=4
- Sub-module ifetch_next_pc: purely combinational next_pc selection (priority mux and jump concatenation). The FSM and registers stay in the top module.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: hold reset=0 for 2 cycles, release; imem_ready asserted 1 cycle after each req.
  - Response: imem_addr 0,1,2; pc_out 0x0,0x4,0x8; instr_valid pulses once per instruction.
- Delayed ready:
  - Stimulus: ready held off 3 cycles.
  - Response: FSM stays in FETCH with imem_req=1 and instr_valid=0; Instruction loads on the ready cycle.
- Branch:
  - beq, Zero=1, Addr_result=0x40 -> next pc_out=0x40.
  - bne, Zero=1 -> next pc_out=PC+4.
- Jal then jr:
  - Stimulus: jal at PC=0x10 with imm26=0x20.
  - Response: pc_out=0x80, link_addr=0x14.
  - Then: Jr with Read_data_1=0x14 -> pc_out=0x14.
- Stall and reset mid-fetch:
  - stall=1 for 4 EXEC cycles -> PC and Instruction stable, instr_valid=1 throughout.
  - reset=0 during FETCH with a pending ready -> PC=RESET_PC, Instruction=0, and the ready is ignored.
- Align check (macro defined):
  - Stimulus: Jr with Read_data_1=0x22.
  - Response: addr_err=1, state HALT, pc_out unchanged, imem_req=0 until reset.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch PC controller.
// Contents: FSM state encoding, default reset PC, PC increment and a PC+4 helper.
// Latency/backpressure: n/a (declarations only).
package ifetch_pkg;

  // HALT is only reachable when IFETCH_ALIGN_CHECK_EN is defined.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus_inc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// ifetch_next_pc: next-PC selection (Jr > Jmp/Jal > taken branch > PC+4).
// Ports: pc, instr_index (Instruction[25:0]), execute results and jump controls in;
//        pc_plus4 and next_pc out. Purely combinational, zero latency, no backpressure.
module ifetch_next_pc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic [31:0] Addr_result,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        branch_taken;

  assign pc_plus4     = pc_plus_inc(pc);
  // Pseudo-direct jump: keep the region bits of PC+4, word index from the instruction.
  assign jump_target  = {pc_plus4[31:28], instr_index, 2'b00};
  // Register targets are word-aligned by masking; misalignment is flagged upstream if enabled.
  assign jr_target    = Read_data_1 & ~32'h0000_0003;
  // Branch and nBranch together is illegal; the OR of both taken terms falls out naturally.
  assign branch_taken = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    next_pc = pc_plus4;
    if (Jr) begin
      next_pc = jr_target;
    end else if (Jmp | Jal) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = Addr_result;
    end
  end

endmodule

// File: rtl/ifetch_pc_ctrl.sv
// ifetch_pc_ctrl: PC owner and instruction fetch (FETCH <-> EXEC FSM) feeding decode/execute.
// Latency: >=1 cycle per fetch (imem_req until imem_ready), then >=1 EXEC cycle per instruction.
// Backpressure: imem side waits on imem_ready; execute holds the instruction with stall.
// Ports: clock/reset (sync, active-low); imem_req/imem_addr/imem_ready/imem_rdata fetch port;
//        Instruction/instr_valid/branch_base_addr/pc_out to execute; Addr_result, Zero,
//        Read_data_1, Branch, nBranch, Jmp, Jal, Jr, stall from execute; link_addr for jal.
// Optional: IFETCH_ALIGN_CHECK_EN adds sticky addr_err and a HALT state on misaligned Jr.
module ifetch_pc_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter int          ADDR_W   = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       Addr_result,
  input  logic              Zero,
  input  logic [31:0]       Read_data_1,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic [31:0]       branch_base_addr,
  output logic [31:0]       link_addr,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic              addr_err,
`endif
  output logic [31:0]       pc_out
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pc_ld;
  logic        instr_ld;
  logic        link_ld;
  logic        req_c;
  logic        valid_c;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        err_set;
  logic        jr_misaligned;

  assign jr_misaligned = Jr & (Read_data_1[1:0] != 2'b00);
`endif

  ifetch_next_pc u_next_pc (
    .pc          (pc),
    .instr_index (Instruction[25:0]),
    .Addr_result (Addr_result),
    .Zero        (Zero),
    .Read_data_1 (Read_data_1),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  // Next-state and per-cycle enables.
  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    instr_ld  = 1'b0;
    link_ld   = 1'b0;
    req_c     = 1'b0;
    valid_c   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_set   = 1'b0;
`endif
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (imem_ready) begin
          instr_ld  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        valid_c = 1'b1;
        if (!stall) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (jr_misaligned) begin
            // PC is frozen on the faulting instruction for post-mortem inspection.
            err_set   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_ld     = 1'b1;
            link_ld   = Jal;
            state_nxt = FETCH;
          end
`else
          pc_ld     = 1'b1;
          link_ld   = Jal;
          state_nxt = FETCH;
`endif
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      HALT: begin
        state_nxt = HALT;
      end
`endif
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      Instruction <= 32'h0;
      link_addr   <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (pc_ld) begin
        pc <= next_pc;
      end
      if (instr_ld) begin
        Instruction <= imem_rdata;
      end
      if (link_ld) begin
        link_addr <= pc_plus4;
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      if (err_set) begin
        addr_err <= 1'b1;
      end
`endif
    end
  end

  // The request is masked while reset is held so a stale FETCH state never reaches memory.
  assign imem_req         = req_c & reset;
  assign imem_addr        = pc[ADDR_W+1:2];
  assign instr_valid      = valid_c;
  assign branch_base_addr = pc_plus4;
  assign pc_out           = pc;

endmodule

// File: tb/tb_ifetch_pc_ctrl.sv
// tb_ifetch_pc_ctrl: directed plus randomized fetch/branch/jump sequences against an
// architectural PC/link model; imem responder and execute controls driven by the bench.
module tb_ifetch_pc_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] Addr_result;
  logic        Zero;
  logic [31:0] Read_data_1;
  logic        Branch, nBranch, Jmp, Jal, Jr, stall;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] branch_base_addr;
  logic [31:0] link_addr;
  logic [31:0] pc_out;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int errors = 0;
  int checks = 0;

  // Architectural model state.
  logic [31:0] m_pc;
  logic [31:0] m_link;

  ifetch_pc_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .Addr_result      (Addr_result),
    .Zero             (Zero),
    .Read_data_1      (Read_data_1),
    .Branch           (Branch),
    .nBranch          (nBranch),
    .Jmp              (Jmp),
    .Jal              (Jal),
    .Jr               (Jr),
    .stall            (stall),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .Instruction      (Instruction),
    .instr_valid      (instr_valid),
    .branch_base_addr (branch_base_addr),
    .link_addr        (link_addr),
`ifdef IFETCH_ALIGN_CHECK_EN
    .addr_err         (addr_err),
`endif
    .pc_out           (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_ctrl();
    Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0; stall = 0;
    Addr_result = 32'h0; Read_data_1 = 32'h0;
  endtask

  // One full instruction: fetch with dly wait cycles, stl stall cycles, then retire.
  task automatic run_instr(input logic [31:0] w, input int dly, input int stl,
                           input logic br, input logic nbr, input logic jmp,
                           input logic jal, input logic jr, input logic zero,
                           input logic [31:0] rd1, input logic [31:0] ares);
    logic [31:0] p4;
    logic [31:0] nxt;
    #1;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc[15:2]);
    check("fetch_valid", instr_valid, 0);
    check("fetch_pc", pc_out, m_pc);
    for (int i = 0; i < dly; i++) begin
      imem_ready = 0;
      imem_rdata = $urandom;
      tick();
      #1;
      check("wait_req", imem_req, 1);
      check("wait_valid", instr_valid, 0);
    end
    imem_ready = 1;
    imem_rdata = w;
    tick();
    imem_ready = 0;
    Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr; Zero = zero;
    Read_data_1 = rd1; Addr_result = ares;

    p4 = m_pc + 32'd4;
    if (jr)
      nxt = rd1 & 32'hFFFF_FFFC;
    else if (jmp || jal)
      nxt = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    else if ((br && zero) || (nbr && !zero))
      nxt = ares;
    else
      nxt = p4;

    for (int i = 0; i <= stl; i++) begin
      stall = (i < stl);
      // Ready during EXEC must be ignored.
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      #1;
      check("exec_valid", instr_valid, 1);
      check("exec_instr", Instruction, w);
      check("exec_pc", pc_out, m_pc);
      check("exec_bba", branch_base_addr, p4);
      check("exec_req", imem_req, 0);
      check("exec_link", link_addr, m_link);
      tick();
    end
    imem_ready = 0;
    clear_ctrl();
    if (jal) m_link = p4;
    m_pc = nxt;
    #1;
    check("retire_pc", pc_out, m_pc);
    check("retire_link", link_addr, m_link);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("retire_err", addr_err, 0);
`endif
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] rd1;
    int          kind;
    logic        zr;

    reset = 0;
    imem_ready = 0;
    imem_rdata = 32'h0;
    clear_ctrl();
    m_pc = 32'h0;
    m_link = 32'h0;

    // Reset state.
    tick();
    tick();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_link", link_addr, 32'h0);
    check("rst_bba", branch_base_addr, 32'h4);
    reset = 1;

    // Sequential fetch, ready one cycle after the request.
    for (int i = 0; i < 3; i++)
      run_instr($urandom, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Delayed ready.
    run_instr(32'h1234_5678, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    // beq taken.
    run_instr(32'h1000_0000, 0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h40);
    check("beq_pc", pc_out, 32'h40);
    // bne with Zero=1 not taken.
    run_instr(32'h1400_0000, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 32'h100);
    check("bne_pc", pc_out, 32'h44);
    // Get to 0x10, then jal imm26=0x20.
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h0);
    run_instr(32'h0C00_0020, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("jal_pc", pc_out, 32'h80);
    check("jal_link", link_addr, 32'h14);
    run_instr(32'h03E0_0008, 0, 0, 0, 0, 0, 0, 1, 0, 32'h14, 32'h0);
    check("jr_pc", pc_out, 32'h14);
    // Stall held four EXEC cycles.
    run_instr(32'hABCD_0001, 0, 4, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Priority: Jr over Jal and branch; jump over taken branch.
    run_instr(32'h0C00_0100, 0, 0, 1, 0, 0, 1, 1, 1, 32'h200, 32'h300);
    check("prio_jr", pc_out, 32'h200);
    run_instr(32'h0800_0100, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0, 32'h300);
    check("prio_jmp", pc_out, 32'h400);
    // PC+4 wrap.
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_pc", pc_out, 32'h0);
`ifndef IFETCH_ALIGN_CHECK_EN
    // Misaligned Jr target is masked.
    run_instr(32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h23, 32'h0);
    check("jr_mask", pc_out, 32'h20);
`endif

    // Reset during FETCH with a ready pending.
    #1;
    reset = 0;
    imem_ready = 1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    #1;
    check("mrst_req", imem_req, 0);
    check("mrst_pc", pc_out, 32'h0);
    check("mrst_instr", Instruction, 32'h0);
    check("mrst_valid", instr_valid, 0);
    check("mrst_link", link_addr, 32'h0);
    reset = 1;
    imem_ready = 0;
    tick();
    #1;
    check("post_rst_instr", Instruction, 32'h0);
    check("post_rst_valid", instr_valid, 0);
    m_pc = 32'h0;
    m_link = 32'h0;

    // Randomized sequences.
    for (int n = 0; n < 150; n++) begin
      w    = $urandom;
      kind = $urandom_range(0, 7);
      rd1  = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
      rd1  = rd1 & 32'hFFFF_FFFC;
`endif
      zr   = 1'($urandom_range(0, 1));
      case (kind)
        0: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 1, 0, 0, 0, 0, zr, rd1, $urandom & 32'hFFFF_FFFC);
        1: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 1, 0, 0, 0, zr, rd1, $urandom & 32'hFFFF_FFFC);
        2: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 1, 0, 0, zr, rd1, $urandom);
        3: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 0, 1, 0, zr, rd1, $urandom);
        4: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 0, 0, 1, zr, rd1, $urandom);
        5: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), zr, rd1, $urandom & 32'hFFFF_FFFC);
        default: run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, 0, 0, 0, zr, rd1, $urandom);
      endcase
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Misaligned Jr halts with PC frozen.
    #1;
    imem_ready = 1;
    imem_rdata = 32'h03E0_0008;
    tick();
    imem_ready = 0;
    Jr = 1;
    Read_data_1 = 32'h22;
    #1;
    check("al_exec_valid", instr_valid, 1);
    tick();
    clear_ctrl();
    #1;
    check("al_err", addr_err, 1);
    check("al_pc", pc_out, m_pc);
    check("al_req", imem_req, 0);
    check("al_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1;
      tick();
      #1;
      check("halt_req", imem_req, 0);
      check("halt_err", addr_err, 1);
      check("halt_pc", pc_out, m_pc);
    end
    imem_ready = 0;
    reset = 0;
    tick();
    reset = 1;
    #1;
    check("al_rst_err", addr_err, 0);
    check("al_rst_pc", pc_out, 32'h0);
    check("al_rst_req", imem_req, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
